// File: rtl/plab4_net_router_input_queue_pkg.sv
// Shared network message layout and helpers for the ring router input queue.
package plab4_net_router_input_queue_pkg;

  localparam int c_net_msg_nbits      = 44;
  localparam int c_net_msg_dest_lsb   = 33;
  localparam int c_net_msg_dest_nbits = 3;
  localparam int c_num_entries        = 4;
  localparam int c_num_free_nbits     = 3;

  typedef logic [c_net_msg_nbits-1:0] net_msg_t;

  // A depth-1 queue would still need a one-bit pointer to stay legal.
  function automatic int queue_ptr_nbits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/plab4_net_router_input_queue_if.sv
// Valid/ready message channel used on both sides of the router input queue.
interface plab4_net_router_input_queue_if
  import plab4_net_router_input_queue_pkg::*;
#(
  parameter int p_msg_nbits = c_net_msg_nbits
);
  logic                   val;
  logic                   rdy;
  logic [p_msg_nbits-1:0] msg;

  modport master (output val, output msg, input rdy);
  modport slave  (input val, input msg, output rdy);
endinterface

// File: rtl/plab4_net_router_input_queue_dpath.sv
// Storage array for the input queue: one write port at tail, one read port at head.
module plab4_net_router_input_queue_dpath #(
  parameter int p_msg_nbits   = 44,
  parameter int p_num_entries = 4,
  parameter int p_ptr_nbits   = 2
) (
  input  logic                   clk,
  input  logic                   wen,
  input  logic [p_ptr_nbits-1:0] waddr,
  input  logic [p_msg_nbits-1:0] wdata,
  input  logic [p_ptr_nbits-1:0] raddr,
  output logic [p_msg_nbits-1:0] rdata
);

  logic [p_msg_nbits-1:0] storage [p_num_entries];

  // Contents are deliberately not reset; occupancy is tracked by the control.
  always_ff @(posedge clk) begin
    if (wen) storage[waddr] <= wdata;
  end

  assign rdata = storage[raddr];

endmodule

// File: rtl/plab4_net_router_input_queue.sv
// Per-port ring router input buffer: plain FIFO (no bypass) with a free-entry
// count published for bubble flow control.
module plab4_net_router_input_queue
  import plab4_net_router_input_queue_pkg::*;
#(
  parameter int p_msg_nbits      = c_net_msg_nbits,
  parameter int p_dest_lsb       = c_net_msg_dest_lsb,
  parameter int p_dest_nbits     = c_net_msg_dest_nbits,
  parameter int p_num_entries    = c_num_entries,
  parameter int p_num_free_nbits = c_num_free_nbits
) (
  input  logic                        clk,
  input  logic                        reset,
  plab4_net_router_input_queue_if.slave  enq,
  plab4_net_router_input_queue_if.master deq,
  output logic [p_dest_nbits-1:0]     deq_dest,
  output logic [p_num_free_nbits-1:0] num_free_entries
);

  localparam int c_ptr_nbits = queue_ptr_nbits(p_num_entries);
  localparam logic [c_ptr_nbits-1:0]      c_last_ptr = c_ptr_nbits'(p_num_entries - 1);
  localparam logic [p_num_free_nbits-1:0] c_depth    = p_num_free_nbits'(p_num_entries);

  logic [c_ptr_nbits-1:0]      head;
  logic [c_ptr_nbits-1:0]      tail;
  logic [p_num_free_nbits-1:0] count;
  logic                        enq_fire;
  logic                        deq_fire;

  assign enq.rdy  = (count != c_depth);
  assign deq.val  = (count != '0);
  assign enq_fire = enq.val & enq.rdy & ~reset;
  assign deq_fire = deq.val & deq.rdy & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_fire) tail <= (tail == c_last_ptr) ? '0 : tail + 1'b1;
      if (deq_fire) head <= (head == c_last_ptr) ? '0 : head + 1'b1;
      if (enq_fire && !deq_fire)      count <= count + 1'b1;
      else if (deq_fire && !enq_fire) count <= count - 1'b1;
    end
  end

  assign num_free_entries = c_depth - count;

  plab4_net_router_input_queue_dpath #(
    .p_msg_nbits   (p_msg_nbits),
    .p_num_entries (p_num_entries),
    .p_ptr_nbits   (c_ptr_nbits)
  ) dpath (
    .clk   (clk),
    .wen   (enq_fire),
    .waddr (tail),
    .wdata (enq.msg),
    .raddr (head),
    .rdata (deq.msg)
  );

  assign deq_dest = deq.msg[p_dest_lsb +: p_dest_nbits];

endmodule

// File: tb/tb_plab4_net_router_input_queue.sv
// Scoreboard bench for the router input queue: stimulus pushes expected
// messages, a negedge monitor pops and compares on every dequeue.
module tb_plab4_net_router_input_queue;
  import plab4_net_router_input_queue_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] deq_dest;
  logic [2:0] num_free_entries;

  plab4_net_router_input_queue_if #(.p_msg_nbits(44)) enq_if ();
  plab4_net_router_input_queue_if #(.p_msg_nbits(44)) deq_if ();

  plab4_net_router_input_queue dut (
    .clk              (clk),
    .reset            (reset),
    .enq              (enq_if),
    .deq              (deq_if),
    .deq_dest         (deq_dest),
    .num_free_entries (num_free_entries)
  );

  always #5 clk = ~clk;

  net_msg_t exp_q [$];
  int       model_count = 0;
  bit       started = 1'b0;
  int       n_vec = 0;
  int       n_fail = 0;

  function automatic net_msg_t mk(input int dest, input int id);
    net_msg_t m;
    logic [31:0] id_bits;
    logic [2:0]  dest_bits;
    id_bits   = id;
    dest_bits = dest[2:0];
    m         = '0;
    m[43:36]  = 8'hA5;
    m[35:33]  = dest_bits;
    m[31:0]   = id_bits;
    return m;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The model advances on the edge that samples the inputs, then new inputs go out.
  task automatic apply_stimulus(input logic rst, input logic ev, input logic dr, input net_msg_t m);
    bit e;
    bit d;
    @(posedge clk);
    if (reset) begin
      model_count = 0;
      exp_q.delete();
    end else begin
      e = enq_if.val && (model_count != 4);
      d = deq_if.rdy && (model_count != 0);
      if (e) exp_q.push_back(enq_if.msg);
      model_count = model_count + int'(e) - int'(d);
    end
    started = 1'b1;
    #1;
    reset      = rst;
    enq_if.val = ev;
    deq_if.rdy = dr;
    enq_if.msg = m;
  endtask

  always @(negedge clk) begin
    net_msg_t exp_msg;
    logic [2:0] exp_dest;
    if (started) begin
      check("deq_val", 64'(deq_if.val), 64'(model_count != 0));
      check("enq_rdy", 64'(enq_if.rdy), 64'(model_count != 4));
      check("num_free", 64'(num_free_entries), 64'(4 - model_count));
      if (!reset && deq_if.val && deq_if.rdy) begin
        if (exp_q.size() == 0) begin
          check("deq_unexpected", 64'(1), 64'(0));
        end else begin
          exp_msg  = exp_q.pop_front();
          exp_dest = exp_msg[35:33];
          check("deq_msg", 64'(deq_if.msg), 64'(exp_msg));
          check("deq_dest", 64'(deq_dest), 64'(exp_dest));
        end
      end
    end
  end

  initial begin
    net_msg_t r;
    enq_if.val = 1'b1;
    enq_if.msg = mk(5, 1000);
    deq_if.rdy = 1'b0;

    // Reset held with a valid enqueue pending must not write anything.
    apply_stimulus(1, 1, 0, mk(5, 1001));
    apply_stimulus(1, 1, 1, mk(5, 1002));
    apply_stimulus(0, 0, 0, '0);
    apply_stimulus(0, 0, 1, '0);

    // Single enqueue with dest=3: visible only after the write edge.
    apply_stimulus(0, 1, 0, mk(3, 1));
    apply_stimulus(0, 0, 0, '0);
    apply_stimulus(0, 0, 1, '0);
    apply_stimulus(0, 0, 0, '0);

    // Fill to full, try a fifth, then full with both sides active.
    for (int i = 0; i < 4; i++) apply_stimulus(0, 1, 0, mk(i, 16 + i));
    apply_stimulus(0, 1, 0, mk(7, 99));
    apply_stimulus(0, 1, 1, mk(6, 98));
    apply_stimulus(0, 0, 0, '0);
    for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 1, '0);

    // One resident entry, then simultaneous enq/deq long enough to wrap twice.
    apply_stimulus(0, 1, 0, mk(1, 40));
    for (int i = 0; i < 10; i++) apply_stimulus(0, 1, 1, mk(i % 8, 50 + i));
    apply_stimulus(0, 0, 1, '0);
    apply_stimulus(0, 0, 1, '0);

    // Random traffic with a reset dropped into the middle.
    for (int i = 0; i < 1000; i++) begin
      r = {12'($urandom), 32'($urandom)};
      apply_stimulus((i == 500) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r);
    end

    apply_stimulus(0, 0, 1, '0);
    for (int i = 0; i < 6; i++) apply_stimulus(0, 0, 1, '0);
    apply_stimulus(0, 0, 0, '0);
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
